// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader/responder.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } imem_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Little-endian word assembly: b lands in lane cnt, higher lanes are zero-filled.
   function automatic logic [31:0] pack_word(input logic [23:0] low,
                                             input logic [1:0]  cnt,
                                             input logic [7:0]  b);
      logic [31:0] w;
      case (cnt)
         2'd0:    w = {24'h00_0000, b};
         2'd1:    w = {16'h0000, b, low[7:0]};
         2'd2:    w = {8'h00, b, low[15:0]};
         default: w = {b, low};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Core fetch port plus byte-serial loader port of the instruction memory.
interface imem_loader_if #(
   parameter int DEPTH = 256
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0] instr_addr;
   logic [31:0] instr;
   logic        core_rst;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_err;
   logic [AW:0] ld_words;

   modport master (
      output instr_addr, ld_start, ld_valid, ld_byte, ld_last,
      input  instr, core_rst, ld_ready, ld_err, ld_words
   );

   modport slave (
      input  instr_addr, ld_start, ld_valid, ld_byte, ld_last,
      output instr, core_rst, ld_ready, ld_err, ld_words
   );

endinterface

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: synchronous write, combinational read, no reset.
module imem_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory for the core: byte-serial loader fills the RAM, then
// releases core_rst and serves combinational fetches.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   imem_loader_if.slave bus
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);
   localparam logic [31:0] ADDR_END = 32'(DEPTH * 4);

   imem_state_e   state;
   logic [AW:0]   ptr;
   logic [1:0]    cnt;
   logic [23:0]   shift;
   logic          err;
   logic          core_rst_r;
   logic          ready_r;

   logic          accept;
   logic          full;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;
   logic [AW-1:0] rd_idx;

   // Bytes arriving together with ld_start belong to no load and are dropped.
   assign accept  = bus.ld_valid & ready_r & ~bus.ld_start;
   assign full    = (ptr == PTR_FULL);
   assign wr_en   = accept & ~full & ((cnt == 2'd3) | bus.ld_last);
   assign wr_data = pack_word(shift, cnt, bus.ld_byte);
   assign rd_idx  = bus.instr_addr[AW+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         core_rst_r <= 1'b1;
         ready_r    <= 1'b0;
      end else if (bus.ld_start) begin
         state      <= LOAD;
         ptr        <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         core_rst_r <= 1'b1;
         ready_r    <= 1'b1;
      end else if (accept) begin
         if (full) begin
            err <= 1'b1;
         end else if (wr_en) begin
            ptr <= ptr + 1'b1;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (bus.ld_last) begin
            ready_r <= 1'b0;
            if (err | full) begin
               state      <= IDLE;
               core_rst_r <= 1'b1;
            end else begin
               state      <= RUN;
               core_rst_r <= 1'b0;
            end
         end
      end
   end

   // Byte lanes 0..2 wait here; lane 3 goes straight into the RAM write.
   always_ff @(posedge clk) begin
      if (accept & ~full) begin
         case (cnt)
            2'd0:    shift[7:0]   <= bus.ld_byte;
            2'd1:    shift[15:8]  <= bus.ld_byte;
            2'd2:    shift[23:16] <= bus.ld_byte;
            default: ;
         endcase
      end
   end

   imem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (ptr[AW-1:0]),
      .wdata (wr_data),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   assign bus.instr    = ((state == RUN) && (bus.instr_addr < ADDR_END)) ? rd_data : NOP_INSTR;
   assign bus.core_rst = core_rst_r;
   assign bus.ld_ready = ready_r;
   assign bus.ld_err   = err;
   assign bus.ld_words = ptr;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: DEPTH=256 and DEPTH=4 instances against a byte-level model.
module tb_imem_loader;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          S_IDLE = 0;
   localparam int          S_LOAD = 1;
   localparam int          S_RUN  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  start = '0;
   logic [1:0]  valid = '0;
   logic [1:0]  last  = '0;
   logic [7:0]  lb   [2];
   logic [31:0] addr [2];

   int checks = 0;
   int errors = 0;

   imem_loader_if #(.DEPTH(256)) bus_a ();
   imem_loader_if #(.DEPTH(4))   bus_b ();

   assign bus_a.ld_start   = start[0];
   assign bus_a.ld_valid   = valid[0];
   assign bus_a.ld_last    = last[0];
   assign bus_a.ld_byte    = lb[0];
   assign bus_a.instr_addr = addr[0];
   assign bus_b.ld_start   = start[1];
   assign bus_b.ld_valid   = valid[1];
   assign bus_b.ld_last    = last[1];
   assign bus_b.ld_byte    = lb[1];
   assign bus_b.instr_addr = addr[1];

   imem_loader #(.DEPTH(256)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   imem_loader #(.DEPTH(4))   u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   logic [31:0] o_instr [2];
   logic [31:0] o_words [2];
   logic        o_crst  [2];
   logic        o_rdy   [2];
   logic        o_err   [2];
   assign o_instr[0] = bus_a.instr;
   assign o_instr[1] = bus_b.instr;
   assign o_words[0] = 32'(bus_a.ld_words);
   assign o_words[1] = 32'(bus_b.ld_words);
   assign o_crst[0]  = bus_a.core_rst;
   assign o_crst[1]  = bus_b.core_rst;
   assign o_rdy[0]   = bus_a.ld_ready;
   assign o_rdy[1]   = bus_b.ld_ready;
   assign o_err[0]   = bus_a.ld_err;
   assign o_err[1]   = bus_b.ld_err;

   // Model: load state, committed word count, bytes of the pending word, memory image.
   int          m_state [2];
   int          m_words [2];
   int          m_nb    [2];
   bit          m_err   [2];
   logic [31:0] m_cur   [2];
   logic [31:0] m_mem   [2][256];
   bit          m_known [2][256];

   function automatic int depth_of(input int k);
      return (k == 0) ? 256 : 4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_state[k] = S_IDLE;
      m_words[k] = 0;
      m_nb[k]    = 0;
      m_err[k]   = 1'b0;
   endtask

   task automatic model_step(input int k);
      if (start[k]) begin
         m_state[k] = S_LOAD;
         m_words[k] = 0;
         m_nb[k]    = 0;
         m_err[k]   = 1'b0;
         return;
      end
      if (m_state[k] != S_LOAD || !valid[k]) return;
      if (m_words[k] == depth_of(k)) begin
         m_err[k] = 1'b1;
      end else begin
         if (m_nb[k] == 0) m_cur[k] = 32'(lb[k]);
         else              m_cur[k] = m_cur[k] | (32'(lb[k]) << (8 * m_nb[k]));
         m_nb[k]++;
         if (m_nb[k] == 4 || last[k]) begin
            m_mem[k][m_words[k]]   = m_cur[k];
            m_known[k][m_words[k]] = 1'b1;
            m_words[k]++;
            m_nb[k] = 0;
         end
      end
      if (last[k]) m_state[k] = m_err[k] ? S_IDLE : S_RUN;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 256; i++) m_known[k][i] = 1'b0;
         model_reset(k);
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else        model_step(k);
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int idx;
         chk($sformatf("u%0d core_rst", k), 32'(o_crst[k]), 32'(m_state[k] != S_RUN));
         chk($sformatf("u%0d ld_ready", k), 32'(o_rdy[k]), 32'(m_state[k] == S_LOAD));
         chk($sformatf("u%0d ld_err", k), 32'(o_err[k]), 32'(m_err[k]));
         chk($sformatf("u%0d ld_words", k), o_words[k], 32'(m_words[k]));
         idx = int'(addr[k] >> 2) % depth_of(k);
         if (m_state[k] != S_RUN || addr[k] >= 32'(depth_of(k) * 4))
            chk($sformatf("u%0d instr nop", k), o_instr[k], NOP);
         else if (m_known[k][idx])
            chk($sformatf("u%0d instr", k), o_instr[k], m_mem[k][idx]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start(input int k, input logic v = 1'b0, input logic [7:0] b = 8'h00);
      start[k] = 1'b1;
      valid[k] = v;
      lb[k]    = b;
      tick();
      start[k] = 1'b0;
      valid[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic [7:0] b, input logic l);
      valid[k] = 1'b1;
      lb[k]    = b;
      last[k]  = l;
      tick();
      valid[k] = 1'b0;
      last[k]  = 1'b0;
   endtask

   task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] exp, input string nm);
      addr[k] = a;
      #1;
      chk(nm, (k == 0) ? bus_a.instr : bus_b.instr, exp);
   endtask

   initial begin
      lb[0] = 8'h00; lb[1] = 8'h00;
      addr[0] = 32'h0; addr[1] = 32'h0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // Idle after reset: core held, loader closed, NOP fetched.
      fetch(0, 32'h0, NOP, "idle fetch");
      chk("idle core_rst", 32'(bus_a.core_rst), 32'd1);
      chk("idle ld_ready", 32'(bus_a.ld_ready), 32'd0);

      // Two full words.
      pulse_start(0);
      send(0, 8'h13, 0); send(0, 8'h05, 0); send(0, 8'h10, 0); send(0, 8'h00, 0);
      send(0, 8'h93, 0); send(0, 8'h00, 0); send(0, 8'h50, 0); send(0, 8'h00, 1);
      chk("t2 core_rst", 32'(bus_a.core_rst), 32'd0);
      chk("t2 ld_words", 32'(bus_a.ld_words), 32'd2);
      fetch(0, 32'h4, 32'h0050_0093, "t2 fetch 4");
      fetch(0, 32'h0, 32'h0010_0513, "t2 fetch 0");

      // Partial trailing word; the byte riding on ld_start is ignored.
      pulse_start(0, 1'b1, 8'hEE);
      send(0, 8'hAA, 0); send(0, 8'hBB, 0); send(0, 8'hCC, 0); send(0, 8'hDD, 0);
      send(0, 8'h11, 0); send(0, 8'h22, 1);
      chk("t3 ld_words", 32'(bus_a.ld_words), 32'd2);
      chk("t3 ld_err", 32'(bus_a.ld_err), 32'd0);
      chk("t3 core_rst", 32'(bus_a.core_rst), 32'd0);
      fetch(0, 32'h0, 32'hDDCC_BBAA, "t3 fetch 0");
      fetch(0, 32'h4, 32'h0000_2211, "t3 fetch 4");

      // Out-of-range and misaligned fetch.
      fetch(0, 32'h400, NOP, "t5 fetch 400");
      fetch(0, 32'h6, 32'h0000_2211, "t5 fetch 6");
      tick();

      // Small memory exactly filled, last on final byte.
      pulse_start(1);
      for (int i = 0; i < 16; i++) send(1, 8'(8'h40 + i), (i == 15));
      chk("fill ld_words", 32'(bus_b.ld_words), 32'd4);
      chk("fill core_rst", 32'(bus_b.core_rst), 32'd0);
      fetch(1, 32'hC, 32'h4F4E_4D4C, "fill fetch C");
      fetch(1, 32'h10, NOP, "fill fetch 10");

      // Overflow: 17 bytes into 4 words.
      pulse_start(1);
      for (int i = 0; i < 17; i++) send(1, 8'(i + 1), (i == 16));
      chk("ovf ld_err", 32'(bus_b.ld_err), 32'd1);
      chk("ovf ld_words", 32'(bus_b.ld_words), 32'd4);
      chk("ovf core_rst", 32'(bus_b.core_rst), 32'd1);
      chk("ovf ld_ready", 32'(bus_b.ld_ready), 32'd0);
      fetch(1, 32'h4, NOP, "ovf fetch 4");
      tick();

      // Restart mid-load, then asynchronous reset mid-word.
      pulse_start(0);
      send(0, 8'h01, 0); send(0, 8'h02, 0);
      pulse_start(0);
      chk("restart ld_words", 32'(bus_a.ld_words), 32'd0);
      send(0, 8'h03, 0); send(0, 8'h04, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst core_rst", 32'(bus_a.core_rst), 32'd1);
      chk("rst ld_ready", 32'(bus_a.ld_ready), 32'd0);
      chk("rst ld_words", 32'(bus_a.ld_words), 32'd0);
      chk("rst ld_err b", 32'(bus_b.ld_err), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      pulse_start(0);
      send(0, 8'h13, 1);
      fetch(0, 32'h0, 32'h0000_0013, "post-rst fetch 0");
      fetch(0, 32'h4, 32'h0000_2211, "post-rst fetch 4");
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
